// File: rtl/knn_topk_sorter.sv
// Sorted top-K nearest-neighbour store: keeps the K smallest distances with labels,
// ascending, with a single-cycle parallel insert and a registered indexed read port.
module knn_topk_sorter #(
    parameter int unsigned DIST_W  = 33,
    parameter int unsigned LABEL_W = 8,
    parameter int unsigned K       = 4,
    localparam int unsigned IW     = $clog2(K) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [DIST_W-1:0]  in_dist,
    input  logic [LABEL_W-1:0] in_label,
    input  logic [IW-1:0]      rd_idx,
    output logic [DIST_W-1:0]  rd_dist,
    output logic [LABEL_W-1:0] rd_label,
    output logic               rd_valid,
    output logic [IW-1:0]      count,
    output logic               full,
    output logic               in_accepted
);

    localparam int unsigned SW = (K > 1) ? $clog2(K) : 1;

    logic [K-1:0]         vld_q;
    logic [K-1:0]         vld_d;
    logic [K-1:0]         le;
    logic [DIST_W-1:0]    dist_q  [K];
    logic [DIST_W-1:0]    dist_d  [K];
    logic [LABEL_W-1:0]   label_q [K];
    logic [LABEL_W-1:0]   label_d [K];
    logic [IW-1:0]        count_q;
    logic                 in_accepted_q;
    logic [DIST_W-1:0]    rd_dist_q;
    logic [LABEL_W-1:0]   rd_label_q;
    logic                 rd_valid_q;
    logic                 ins;
    logic                 full_w;
    logic [SW-1:0]        sel;

    // le is a thermometer code (sorted, contiguous list); its popcount is the insert position.
    // Each slot keeps its entry, takes the candidate, or takes its lower neighbour.
    genvar i;
    generate
        for (i = 0; i < K; i++) begin : g_slot
            assign le[i] = vld_q[i] && (dist_q[i] <= in_dist);
            if (i == 0) begin : g_head
                assign vld_d[i]   = 1'b1;
                assign dist_d[i]  = le[i] ? dist_q[i]  : in_dist;
                assign label_d[i] = le[i] ? label_q[i] : in_label;
            end else begin : g_tail
                assign vld_d[i]   = le[i] | vld_q[i-1];
                assign dist_d[i]  = le[i] ? dist_q[i]  : (le[i-1] ? in_dist  : dist_q[i-1]);
                assign label_d[i] = le[i] ? label_q[i] : (le[i-1] ? in_label : label_q[i-1]);
            end
        end
    endgenerate

    assign ins    = in_valid && !le[K-1];
    assign full_w = (count_q == IW'(K));
    assign sel    = rd_idx[SW-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q         <= '0;
            count_q       <= '0;
            in_accepted_q <= 1'b0;
            rd_dist_q     <= '0;
            rd_label_q    <= '0;
            rd_valid_q    <= 1'b0;
            for (int k = 0; k < K; k++) begin
                dist_q[k]  <= '0;
                label_q[k] <= '0;
            end
        end else begin
            // Read samples pre-update slot contents.
            if (rd_idx < IW'(K)) begin
                rd_dist_q  <= dist_q[sel];
                rd_label_q <= label_q[sel];
                rd_valid_q <= vld_q[sel];
            end else begin
                rd_dist_q  <= '0;
                rd_label_q <= '0;
                rd_valid_q <= 1'b0;
            end

            if (clear) begin
                vld_q         <= '0;
                count_q       <= '0;
                in_accepted_q <= 1'b0;
            end else begin
                in_accepted_q <= ins;
                if (ins) begin
                    vld_q <= vld_d;
                    for (int k = 0; k < K; k++) begin
                        dist_q[k]  <= dist_d[k];
                        label_q[k] <= label_d[k];
                    end
                    if (!full_w) begin
                        count_q <= count_q + IW'(1);
                    end
                end
            end
        end
    end

    assign rd_dist     = rd_dist_q;
    assign rd_label    = rd_label_q;
    assign rd_valid    = rd_valid_q;
    assign count       = count_q;
    assign full        = full_w;
    assign in_accepted = in_accepted_q;

endmodule

// File: tb/tb_knn_topk_sorter.sv
// Bench for knn_topk_sorter: directed scenarios plus randomized traffic against a
// queue-based sorted-list model.
module tb_knn_topk_sorter;

    localparam int DW = 33;
    localparam int LW = 8;
    localparam int K  = 4;
    localparam int IW = $clog2(K) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_dist = '0;
    logic [LW-1:0] in_label = '0;
    logic [IW-1:0] rd_idx = '0;
    logic [DW-1:0] rd_dist;
    logic [LW-1:0] rd_label;
    logic          rd_valid;
    logic [IW-1:0] count;
    logic          full;
    logic          in_accepted;

    int checks = 0;
    int errors = 0;

    knn_topk_sorter #(.DIST_W(DW), .LABEL_W(LW), .K(K)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_dist(in_dist), .in_label(in_label), .rd_idx(rd_idx),
        .rd_dist(rd_dist), .rd_label(rd_label), .rd_valid(rd_valid),
        .count(count), .full(full), .in_accepted(in_accepted)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [LW-1:0] l,
                         input logic clr, input int idx);
        in_valid = v;
        in_dist  = d;
        in_label = l;
        clear    = clr;
        rd_idx   = IW'(idx);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_dist = 3;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (count !== 0 || full !== 0 || in_accepted !== 0) begin
            errors++;
            $display("FAIL reset_status got count=%0d full=%0d acc=%0d want 0 0 0",
                     count, full, in_accepted);
        end
        checks++;
        if (rd_valid !== 0 || rd_dist !== 0 || rd_label !== 0) begin
            errors++;
            $display("FAIL reset_rd got v=%0d d=%0d l=%0d want 0 0 0", rd_valid, rd_dist, rd_label);
        end
        rst_n = 1'b1;
        for (int i = 0; i < K; i++) begin
            cycle(1'b0, '0, '0, 1'b0, i);
            checks++;
            if (rd_valid !== 0 || count !== 0 || full !== 0) begin
                errors++;
                $display("FAIL reset_read%0d got v=%0d count=%0d full=%0d want 0 0 0",
                         i, rd_valid, count, full);
            end
        end
    endtask

    task automatic test_sort();
        int dv [4] = '{50, 10, 30, 20};
        int ed [4] = '{10, 20, 30, 50};
        int el [4] = '{2, 4, 3, 1};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, DW'(dv[i]), LW'(i + 1), 1'b0, 0);
            checks++;
            if (in_accepted !== 1'b1) begin
                errors++;
                $display("FAIL sort_acc%0d got %0d want 1", i, in_accepted);
            end
        end
        checks++;
        if (count !== 4 || full !== 1) begin
            errors++;
            $display("FAIL sort_count got count=%0d full=%0d want 4 1", count, full);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, '0, 1'b0, i);
            checks++;
            if (rd_valid !== 1 || rd_dist !== DW'(ed[i]) || rd_label !== LW'(el[i])) begin
                errors++;
                $display("FAIL sort_slot%0d got v=%0d d=%0d l=%0d want 1 %0d %0d",
                         i, rd_valid, rd_dist, rd_label, ed[i], el[i]);
            end
        end
    endtask

    task automatic test_full_drop();
        int ed [4] = '{10, 20, 25, 30};
        int el [4] = '{2, 4, 9, 3};
        cycle(1'b1, DW'(60), LW'(7), 1'b0, 3);
        checks++;
        if (in_accepted !== 0 || count !== 4) begin
            errors++;
            $display("FAIL drop60 got acc=%0d count=%0d want 0 4", in_accepted, count);
        end
        cycle(1'b0, '0, '0, 1'b0, 3);
        checks++;
        if (rd_dist !== 50 || rd_label !== 1) begin
            errors++;
            $display("FAIL drop60_slot3 got d=%0d l=%0d want 50 1", rd_dist, rd_label);
        end
        cycle(1'b1, DW'(25), LW'(9), 1'b0, 0);
        checks++;
        if (in_accepted !== 1 || count !== 4) begin
            errors++;
            $display("FAIL ins25 got acc=%0d count=%0d want 1 4", in_accepted, count);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, '0, 1'b0, i);
            checks++;
            if (rd_valid !== 1 || rd_dist !== DW'(ed[i]) || rd_label !== LW'(el[i])) begin
                errors++;
                $display("FAIL evict_slot%0d got v=%0d d=%0d l=%0d want 1 %0d %0d",
                         i, rd_valid, rd_dist, rd_label, ed[i], el[i]);
            end
        end
    endtask

    task automatic test_ties();
        cycle(1'b0, '0, '0, 1'b1, 0);
        checks++;
        if (count !== 0) begin
            errors++;
            $display("FAIL ties_clear got count=%0d want 0", count);
        end
        cycle(1'b1, DW'(40), LW'('hA), 1'b0, 0);
        cycle(1'b1, DW'(40), LW'('hB), 1'b0, 0);
        cycle(1'b0, '0, '0, 1'b0, 0);
        checks++;
        if (rd_label !== LW'('hA) || rd_dist !== 40) begin
            errors++;
            $display("FAIL ties_slot0 got d=%0d l=%0h want 40 a", rd_dist, rd_label);
        end
        cycle(1'b0, '0, '0, 1'b0, 1);
        checks++;
        if (rd_label !== LW'('hB) || rd_dist !== 40) begin
            errors++;
            $display("FAIL ties_slot1 got d=%0d l=%0h want 40 b", rd_dist, rd_label);
        end
        cycle(1'b1, DW'(40), LW'('hC), 1'b0, 0);
        cycle(1'b1, DW'(40), LW'('hD), 1'b0, 0);
        cycle(1'b1, DW'(40), LW'('hE), 1'b0, 3);
        checks++;
        if (in_accepted !== 0 || count !== 4) begin
            errors++;
            $display("FAIL ties_drop got acc=%0d count=%0d want 0 4", in_accepted, count);
        end
        cycle(1'b0, '0, '0, 1'b0, 3);
        checks++;
        if (rd_label !== LW'('hD)) begin
            errors++;
            $display("FAIL ties_slot3 got l=%0h want d", rd_label);
        end
    endtask

    task automatic test_clear_with_valid();
        cycle(1'b1, DW'(5), LW'(5), 1'b1, 0);
        checks++;
        if (count !== 0 || full !== 0 || in_accepted !== 0) begin
            errors++;
            $display("FAIL clrv_status got count=%0d full=%0d acc=%0d want 0 0 0",
                     count, full, in_accepted);
        end
        for (int i = 0; i < K; i++) begin
            cycle(1'b0, '0, '0, 1'b0, i);
            checks++;
            if (rd_valid !== 0) begin
                errors++;
                $display("FAIL clrv_read%0d got v=%0d want 0", i, rd_valid);
            end
        end
        cycle(1'b1, DW'(7), LW'(7), 1'b0, 0);
        checks++;
        if (in_accepted !== 1 || count !== 1) begin
            errors++;
            $display("FAIL clrv_ins got acc=%0d count=%0d want 1 1", in_accepted, count);
        end
        cycle(1'b0, '0, '0, 1'b0, 0);
        checks++;
        if (rd_valid !== 1 || rd_dist !== 7 || rd_label !== 7) begin
            errors++;
            $display("FAIL clrv_slot0 got v=%0d d=%0d l=%0d want 1 7 7", rd_valid, rd_dist, rd_label);
        end
    endtask

    task automatic test_read_during_insert();
        cycle(1'b0, '0, '0, 1'b1, 0);
        for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(10 * i), LW'(i), 1'b0, 0);
        cycle(1'b1, DW'(5), LW'(5), 1'b0, 2);
        checks++;
        if (rd_valid !== 1 || rd_dist !== 30 || rd_label !== 3) begin
            errors++;
            $display("FAIL rdins_old got v=%0d d=%0d l=%0d want 1 30 3", rd_valid, rd_dist, rd_label);
        end
        cycle(1'b0, '0, '0, 1'b0, 2);
        checks++;
        if (rd_valid !== 1 || rd_dist !== 20 || rd_label !== 2) begin
            errors++;
            $display("FAIL rdins_new got v=%0d d=%0d l=%0d want 1 20 2", rd_valid, rd_dist, rd_label);
        end
        cycle(1'b0, '0, '0, 1'b0, K);
        checks++;
        if (rd_valid !== 0 || rd_dist !== 0 || rd_label !== 0) begin
            errors++;
            $display("FAIL rd_oob got v=%0d d=%0d l=%0d want 0 0 0", rd_valid, rd_dist, rd_label);
        end
    endtask

    task automatic test_reset_midstream();
        rst_n = 1'b0;
        cycle(1'b1, DW'(1), LW'(1), 1'b0, 0);
        checks++;
        if (count !== 0 || in_accepted !== 0 || rd_valid !== 0 || rd_dist !== 0) begin
            errors++;
            $display("FAIL midrst got count=%0d acc=%0d v=%0d d=%0d want 0 0 0 0",
                     count, in_accepted, rd_valid, rd_dist);
        end
        rst_n = 1'b1;
        cycle(1'b0, '0, '0, 1'b0, 0);
        checks++;
        if (rd_valid !== 0) begin
            errors++;
            $display("FAIL midrst_read got v=%0d want 0", rd_valid);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] q_dist [$];
        logic [LW-1:0] q_label [$];
        logic [DW-1:0] d, e_d;
        logic [LW-1:0] l, e_l;
        logic          v, clr, e_v, e_acc, care;
        int            idx, p;
        cycle(1'b0, '0, '0, 1'b1, 0);
        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            d   = ($urandom_range(0, 9) == 0) ? '1 : DW'($urandom_range(0, 15));
            l   = LW'($urandom);
            clr = ($urandom_range(0, 39) == 0);
            idx = $urandom_range(0, K);
            // Expected read is from the list as it stands before this edge.
            e_v  = (idx < q_dist.size());
            care = e_v || (idx >= K);
            e_d  = e_v ? q_dist[idx] : '0;
            e_l  = e_v ? q_label[idx] : '0;
            e_acc = 1'b0;
            if (clr) begin
                q_dist.delete();
                q_label.delete();
            end else if (v) begin
                p = 0;
                foreach (q_dist[j]) if (q_dist[j] <= d) p++;
                if (p < K) begin
                    e_acc = 1'b1;
                    q_dist.insert(p, d);
                    q_label.insert(p, l);
                    if (q_dist.size() > K) begin
                        void'(q_dist.pop_back());
                        void'(q_label.pop_back());
                    end
                end
            end
            cycle(v, d, l, clr, idx);
            checks++;
            if (in_accepted !== e_acc || count !== IW'(q_dist.size())
                || full !== (q_dist.size() == K)) begin
                errors++;
                $display("FAIL rand%0d_status got acc=%0d count=%0d full=%0d want %0d %0d %0d",
                         n, in_accepted, count, full, e_acc, q_dist.size(), q_dist.size() == K);
            end
            checks++;
            if (rd_valid !== e_v || (care && (rd_dist !== e_d || rd_label !== e_l))) begin
                errors++;
                $display("FAIL rand%0d_read idx=%0d got v=%0d d=%0h l=%0h want %0d %0h %0h",
                         n, idx, rd_valid, rd_dist, rd_label, e_v, e_d, e_l);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sort();
        test_full_drop();
        test_ties();
        test_clear_with_valid();
        test_read_during_insert();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
